// File: rtl/load_store_unit_if.sv
// Core request/response and word-memory bus bundle for the load/store unit.
// slave = the load/store unit itself; master = core + memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        mem_read_enable;
    logic [31:0] mem_read_address;
    logic [31:0] mem_read_value;
    logic        mem_write_enable;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_value;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_value,
        output req_ready, resp_valid, resp_rdata, resp_error,
        output mem_read_enable, mem_read_address, mem_write_enable, mem_write_address, mem_write_value
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_read_value,
        input  req_ready, resp_valid, resp_rdata, resp_error,
        input  mem_read_enable, mem_read_address, mem_write_enable, mem_write_address, mem_write_value
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit driving a word-indexed memory: lane extraction, sign extension,
// read-modify-write for sub-word stores, and alignment/range/funct3 fault detection.
module load_store_unit #(
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic clock,
    input  logic reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_WAIT = 3'd2,
        S_WR   = 3'd3,
        S_RESP = 3'd4
    } state_t;

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

    function automatic logic req_fault(input logic write, input logic [2:0] f3, input logic [31:0] addr);
        logic bad_f3;
        logic misal;
        logic oor;
        bad_f3 = write ? (f3 > 3'd2) : ((f3 == 3'b011) || (f3[2:1] == 2'b11));
        case (f3[1:0])
            2'b01:   misal = addr[0];
            2'b10:   misal = (addr[1:0] != 2'b00);
            default: misal = 1'b0;
        endcase
        oor = ({2'b00, addr[31:2]} >= 32'(MEM_WORDS));
        return bad_f3 | misal | oor;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return word;
            3'b100:  return {24'h000000, b};
            3'b101:  return {16'h0000, h};
            default: return 32'h00000000;
        endcase
    endfunction

    // Only the addressed lane is replaced; the rest of the fetched word is written back as-is.
    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] data,
                                                input logic [1:0] f3, input logic [1:0] off);
        logic [31:0] mask;
        logic [31:0] lane;
        case (f3)
            2'b00: begin
                mask = 32'h000000FF << {off, 3'b000};
                lane = {4{data[7:0]}};
            end
            2'b01: begin
                mask = off[1] ? 32'hFFFF0000 : 32'h0000FFFF;
                lane = {2{data}};
            end
            default: begin
                mask = 32'h00000000;
                lane = 32'h00000000;
            end
        endcase
        return (word & ~mask) | (lane & mask);
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write;
    logic [2:0]       r_funct3;
    logic [31:0]      r_addr;
    logic [15:0]      r_wdata;
    logic             r_req_ready;
    logic             r_resp_valid;
    logic [31:0]      r_resp_rdata;
    logic             r_resp_error;
    logic             r_rd_en;
    logic [31:0]      r_rd_addr;
    logic             r_wr_en;
    logic [31:0]      r_wr_addr;
    logic [31:0]      r_wr_val;
    logic             w_accept;
    logic             w_fault;

    assign w_accept = bus.req_valid && r_req_ready;
    assign w_fault  = req_fault(bus.req_write, bus.req_funct3, bus.req_addr);

    // Sequencer; every output is registered on the same edge as the state it belongs to.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_funct3     <= 3'b000;
            r_addr       <= 32'h00000000;
            r_wdata      <= 16'h0000;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h00000000;
            r_resp_error <= 1'b0;
            r_rd_en      <= 1'b0;
            r_rd_addr    <= 32'h00000000;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 32'h00000000;
            r_wr_val     <= 32'h00000000;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h00000000;
            r_resp_error <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write     <= bus.req_write;
                        r_funct3    <= bus.req_funct3;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata[15:0];
                        r_req_ready <= 1'b0;
                        if (w_fault) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= 1'b1;
                        end else if (bus.req_write && (bus.req_funct3 == 3'b010)) begin
                            r_state   <= S_WR;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= {2'b00, bus.req_addr[31:2]};
                            r_wr_val  <= bus.req_wdata;
                        end else begin
                            r_state   <= S_RD;
                            r_rd_en   <= 1'b1;
                            r_rd_addr <= {2'b00, bus.req_addr[31:2]};
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_WAIT;
                    r_cnt   <= '0;
                end
                S_WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        r_rd_en   <= 1'b0;
                        r_rd_addr <= 32'h00000000;
                        if (r_write) begin
                            r_state   <= S_WR;
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= {2'b00, r_addr[31:2]};
                            r_wr_val  <= store_merge(bus.mem_read_value, r_wdata, r_funct3[1:0], r_addr[1:0]);
                        end else begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= load_extract(bus.mem_read_value, r_funct3, r_addr[1:0]);
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WR: begin
                    r_state      <= S_RESP;
                    r_wr_en      <= 1'b0;
                    r_wr_addr    <= 32'h00000000;
                    r_wr_val     <= 32'h00000000;
                    r_resp_valid <= 1'b1;
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                    r_rd_en     <= 1'b0;
                    r_rd_addr   <= 32'h00000000;
                    r_wr_en     <= 1'b0;
                    r_wr_addr   <= 32'h00000000;
                    r_wr_val    <= 32'h00000000;
                end
            endcase
        end
    end

    assign bus.req_ready         = r_req_ready;
    assign bus.resp_valid        = r_resp_valid;
    assign bus.resp_rdata        = r_resp_rdata;
    assign bus.resp_error        = r_resp_error;
    assign bus.mem_read_enable   = r_rd_en;
    assign bus.mem_read_address  = r_rd_addr;
    assign bus.mem_write_enable  = r_wr_en;
    assign bus.mem_write_address = r_wr_addr;
    assign bus.mem_write_value   = r_wr_val;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: two units (read latency 1 and 3) on behavioural word memories.
module tb_load_store_unit;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic mem_clr = 1'b1;
    logic idle_chk = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   timeouts = 0;
    int   done [2] = '{0, 0};

    always #5 clock = ~clock;

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] erd;
        logic        eerr;
        int          elat;
        logic        hw;
        logic [31:0] ewv;
    } req_t;

    req_t        vec [$];
    req_t        exp_q [2][$];
    int          acc_q [2][$];
    logic [63:0] wr_q [2][$];
    bit          en_seen [2] = '{1'b0, 1'b0};

    load_store_unit_if bus1();
    load_store_unit_if bus3();

    load_store_unit #(.MEM_WORDS(1024), .READ_LATENCY(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
    load_store_unit #(.MEM_WORDS(1024), .READ_LATENCY(3)) u_dut3 (.clock(clock), .reset(reset), .bus(bus3));

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem3 [0:1023];
    logic [31:0] p1 = 32'h0;
    logic [31:0] p3 [0:2] = '{32'h0, 32'h0, 32'h0};

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) begin
                mem1[i] <= 32'h0;
                mem3[i] <= 32'h0;
            end
        end else begin
            if (bus1.mem_write_enable) mem1[bus1.mem_write_address[9:0]] <= bus1.mem_write_value;
            if (bus3.mem_write_enable) mem3[bus3.mem_write_address[9:0]] <= bus3.mem_write_value;
        end
        p1    <= bus1.mem_read_enable ? mem1[bus1.mem_read_address[9:0]] : 32'h0;
        p3[0] <= bus3.mem_read_enable ? mem3[bus3.mem_read_address[9:0]] : 32'h0;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
        cyc   <= cyc + 1;
    end
    assign bus1.mem_read_value = p1;
    assign bus3.mem_read_value = p3[2];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic void mon(input int s, input logic v, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic re, input logic rde, input logic [31:0] rda,
                                input logic we, input logic [31:0] wa, input logic [31:0] wv);
        req_t        e;
        logic [63:0] w;
        int          acc;
        if (idle_chk) begin
            chk("idle_req_ready", 32'(rdy), 32'd1);
            chk("idle_resp_valid", 32'(rv), 32'd0);
            chk("idle_resp_rdata", rd, 32'h0);
            chk("idle_resp_error", 32'(re), 32'd0);
            chk("idle_rd_en", 32'(rde), 32'd0);
            chk("idle_rd_addr", rda, 32'h0);
            chk("idle_wr_en", 32'(we), 32'd0);
            chk("idle_wr_addr", wa, 32'h0);
            chk("idle_wr_val", wv, 32'h0);
        end
        if (reset) begin
            acc_q[s].delete();
            en_seen[s] = 1'b0;
        end else begin
            if (v && rdy) acc_q[s].push_back(cyc + 1);
            if (rde || we) en_seen[s] = 1'b1;
            if (we) begin
                if (wr_q[s].size() == 0) chk("write_expected", 32'(wr_q[s].size()), 32'd1);
                else begin
                    w = wr_q[s].pop_front();
                    chk("write_addr", wa, w[63:32]);
                    chk("write_value", wv, w[31:0]);
                end
            end
            if (rv) begin
                if (exp_q[s].size() == 0) chk("resp_expected", 32'(exp_q[s].size()), 32'd1);
                else begin
                    e = exp_q[s].pop_front();
                    acc = (acc_q[s].size() > 0) ? acc_q[s].pop_front() : 0;
                    chk("resp_rdata", rd, e.erd);
                    chk("resp_error", 32'(re), 32'(e.eerr));
                    chk("resp_latency", 32'(cyc + 1 - acc), 32'(e.elat));
                    chk("mem_enable_seen", 32'(en_seen[s]), 32'(!e.eerr));
                end
                en_seen[s] = 1'b0;
                done[s]++;
            end
        end
    endfunction

    always @(negedge clock) begin
        mon(0, bus1.req_valid, bus1.req_ready, bus1.resp_valid, bus1.resp_rdata, bus1.resp_error,
            bus1.mem_read_enable, bus1.mem_read_address, bus1.mem_write_enable, bus1.mem_write_address, bus1.mem_write_value);
        mon(1, bus3.req_valid, bus3.req_ready, bus3.resp_valid, bus3.resp_rdata, bus3.resp_error,
            bus3.mem_read_enable, bus3.mem_read_address, bus3.mem_write_enable, bus3.mem_write_address, bus3.mem_write_value);
    end

    task automatic drive(input int s, input logic v, input req_t r);
        if (s == 0) begin
            bus1.req_valid = v; bus1.req_write = r.w; bus1.req_funct3 = r.f3;
            bus1.req_addr = r.a; bus1.req_wdata = r.wd;
        end else begin
            bus3.req_valid = v; bus3.req_write = r.w; bus3.req_funct3 = r.f3;
            bus3.req_addr = r.a; bus3.req_wdata = r.wd;
        end
    endtask

    function automatic logic rdy(input int s);
        return (s == 0) ? bus1.req_ready : bus3.req_ready;
    endfunction

    task automatic add(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] erd, input logic eerr, input int elat, input logic hw, input logic [31:0] ewv);
        req_t r;
        r.w = w; r.f3 = f3; r.a = a; r.wd = wd; r.erd = erd;
        r.eerr = eerr; r.elat = elat; r.hw = hw; r.ewv = ewv;
        vec.push_back(r);
    endtask

    // Issues every queued request back-to-back with req_valid held high, then waits for completions.
    task automatic run(input int s);
        req_t r;
        int   target;
        int   t;
        target = done[s] + vec.size();
        while (vec.size() > 0) begin
            r = vec.pop_front();
            @(posedge clock); #1;
            exp_q[s].push_back(r);
            if (r.hw) wr_q[s].push_back({2'b00, r.a[31:2], r.ewv});
            drive(s, 1'b1, r);
            t = 0;
            @(negedge clock);
            while (!rdy(s) && t < 64) begin
                @(negedge clock);
                t++;
            end
            if (!rdy(s)) begin
                $display("FAIL accept_timeout: dut %0d never ready, required ready within 64 cycles", s);
                timeouts++;
                drive(s, 1'b0, r);
                vec.delete();
                return;
            end
        end
        @(posedge clock); #1;
        drive(s, 1'b0, r);
        t = 0;
        while (done[s] < target && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (done[s] < target) begin
            $display("FAIL resp_timeout: dut %0d got %0d responses, required %0d", s, done[s], target);
            timeouts++;
        end
    endtask

    initial begin
        req_t z;
        z = '{w: 1'b0, f3: 3'b000, a: 32'h0, wd: 32'h0, erd: 32'h0, eerr: 1'b0, elat: 0, hw: 1'b0, ewv: 32'h0};
        drive(0, 1'b0, z);
        drive(1, 1'b0, z);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0; mem_clr = 1'b0;
        @(negedge clock); #1 idle_chk = 1'b0;

        // Word store then load, read latency 1
        add(1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 32'hDEADBEEF);
        add(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b0, 32'h0);
        // Byte store/load
        add(1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 1'b0, 2, 1'b1, 32'h11223344);
        add(1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0, 1'b0, 4, 1'b1, 32'h1122A544);
        add(1'b0, 3'b000, 32'h101, 32'h0, 32'hFFFFFFA5, 1'b0, 3, 1'b0, 32'h0);
        add(1'b0, 3'b100, 32'h101, 32'h0, 32'h000000A5, 1'b0, 3, 1'b0, 32'h0);
        // Half store/load, plus top/bottom byte lanes of the result
        add(1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 1'b0, 2, 1'b1, 32'h11223344);
        add(1'b1, 3'b001, 32'h102, 32'h00008001, 32'h0, 1'b0, 4, 1'b1, 32'h80013344);
        add(1'b0, 3'b001, 32'h102, 32'h0, 32'hFFFF8001, 1'b0, 3, 1'b0, 32'h0);
        add(1'b0, 3'b101, 32'h102, 32'h0, 32'h00008001, 1'b0, 3, 1'b0, 32'h0);
        add(1'b0, 3'b000, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b0, 32'h0);
        add(1'b0, 3'b100, 32'h100, 32'h0, 32'h00000044, 1'b0, 3, 1'b0, 32'h0);
        // Last legal word
        add(1'b1, 3'b010, 32'hFFC, 32'h5A5A0001, 32'h0, 1'b0, 2, 1'b1, 32'h5A5A0001);
        add(1'b0, 3'b010, 32'hFFC, 32'h0, 32'h5A5A0001, 1'b0, 3, 1'b0, 32'h0);
        // Faults: misaligned, out of range, illegal funct3
        add(1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        add(1'b1, 3'b001, 32'h103, 32'h1234, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        add(1'b0, 3'b010, 32'h1000, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        add(1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        add(1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        add(1'b0, 3'b101, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        add(1'b1, 3'b000, 32'h1003, 32'hFF, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        add(1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 32'h0, 1'b0, 2, 1'b1, 32'hCAFEF00D);
        run(0);

        // Reset while the SB read is in flight: no write must reach memory
        z.w = 1'b1; z.f3 = 3'b000; z.a = 32'h104; z.wd = 32'h00000077;
        @(posedge clock); #1 drive(0, 1'b1, z);
        @(posedge clock); #1 drive(0, 1'b0, z);
        @(posedge clock); #2 reset = 1'b1; idle_chk = 1'b1;
        @(negedge clock); #1 idle_chk = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0; idle_chk = 1'b1;
        @(negedge clock); #1 idle_chk = 1'b0;
        add(1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b0, 32'h0);
        run(0);

        // Read latency 3, back-to-back with req_valid held high
        add(1'b1, 3'b010, 32'h100, 32'h0BADCAFE, 32'h0, 1'b0, 2, 1'b1, 32'h0BADCAFE);
        add(1'b0, 3'b010, 32'h100, 32'h0, 32'h0BADCAFE, 1'b0, 5, 1'b0, 32'h0);
        add(1'b1, 3'b000, 32'h100, 32'h00000011, 32'h0, 1'b0, 6, 1'b1, 32'h0BADCA11);
        add(1'b0, 3'b101, 32'h102, 32'h0, 32'h00000BAD, 1'b0, 5, 1'b0, 32'h0);
        add(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
        add(1'b0, 3'b000, 32'h100, 32'h0, 32'h00000011, 1'b0, 5, 1'b0, 32'h0);
        run(1);

        repeat (4) @(posedge clock);
        $display("%0d/%0d checks passed", passes, checks + timeouts);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, required completion earlier");
        $fatal(1);
    end
endmodule
